fir_data_sequencer: RTL and testbench
=====================================

Name: fir_data_sequencer

Overview:
Stream-side FIR engine that sits directly upstream of the tap and data bram11 instances. It writes each accepted AXI-Stream sample into the data BRAM as an 11-entry circular shift buffer. It then walks both BRAMs to compute one multiply-accumulate per cycle and emits the filtered sample on an output stream. Tap coefficients are written by the AXI-Lite block; this block only reads the tap BRAM.

Parameters:
TAPS, 11, number of FIR taps and data-buffer depth in words
DATA_W, 32, sample, tap and accumulator width
ADDR_W, 12, BRAM byte-address width

Ports:
CLK  in  1  single clock for the whole block
RST  in  1  synchronous, active-high reset
ap_start  in  1  one-cycle start pulse, honoured only when idle
data_length  in  32  number of samples in the run, sampled on ap_start
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse when the run completes
ss_tvalid  in  1  input stream valid
ss_tdata  in  32  input sample
ss_tready  out  1  input stream ready
sm_tvalid  out  1  output stream valid
sm_tdata  out  32  output sample
sm_tlast  out  1  high with the last output sample
tap_EN  out  1  tap BRAM enable
tap_A  out  12  tap BRAM byte address
tap_Do  in  32  tap BRAM read data (combinational read)
data_WE  out  4  data BRAM byte write enables
data_EN  out  1  data BRAM enable
data_A  out  12  data BRAM byte address
data_Di  out  32  data BRAM write data
data_Do  in  32  data BRAM read data (combinational read)

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state=IDLE, ap_idle=1, all other outputs 0, head=0, count=0, acc=0. BRAM contents are not touched by reset.
- RST asserted mid-run aborts the run immediately. No ap_done is issued.
- BRAM addressing: all BRAM addresses are word index<<2. BRAM reads are combinational, so data is usable in the same cycle as the address. Writes land at the posedge.
- IDLE: on ap_start, latch data_length, set head=0 and count=0, go to CLEAR. ap_start in any other state is ignored.
- CLEAR (TAPS cycles, k=0..10): data_EN=1, data_WE=4'hF, data_A=k<<2, data_Di=0. Then go to WAIT_IN, or to DONE if length==0.
- WAIT_IN: ss_tready=1. On ss_tvalid&&ss_tready:
  - write the sample to data[head] (data_WE=4'hF, data_EN=1);
  - clear acc;
  - go to MAC with k=0.
- MAC (TAPS cycles, k=0..10):
  - tap_EN=1, tap_A=k<<2; data_EN=1, data_WE=0;
  - data_A=((head-k) mod TAPS)<<2, with the subtraction wrapping 0 -> 10;
  - acc <= acc + tap_Do*data_Do: signed multiply, low 32 bits kept, two's-complement wrap, no saturation.
  - After k=10, go to OUT.
- OUT: sm_tvalid=1, sm_tdata=acc, sm_tlast=(count==length-1).
  - Hold all three stable until sm_tready.
  - On the handshake: head <= (head==10)?0:head+1; count++; go to DONE if that was the last sample, else WAIT_IN.
- DONE: ap_done=1 for one cycle, then IDLE.
- Latency: input handshake at cycle T gives sm_tvalid at T+12, so throughput is at best one sample per 13 cycles.
- ss_tready is 0 outside WAIT_IN. No sample is buffered while MAC or OUT is active.
- tap_EN and data_EN are 0 in IDLE, OUT and DONE.

Test Plan:
- Reset: hold RST 3 cycles -> ap_idle=1; ss_tready, sm_tvalid, ap_done, data_WE and data_EN all 0.
- Impulse: taps 1..11, data_length=12, inputs 1 then 11 zeros -> outputs 1,2,...,11,0. sm_tlast only on the 12th output. ap_done pulses once. Each sm_tvalid appears 12 cycles after its input handshake.
- Clear between runs: run 1 with all taps=1 and inputs 5,5,5; then run 2 (length 1) with input 1 -> run-2 output is exactly 1, proving CLEAR wrote 11 zero words.
- Backpressure and wrap: with sm_tready held 0 for 5 cycles, sm_tdata and sm_tlast stay stable and ss_tready stays 0. Separately, tap0=0x7FFFFFFF with input 2 -> output 0xFFFFFFFE.
- Circular wrap: taps all 1, length 15, inputs 1..15 -> output n equals the sum of the last min(n,11) inputs. Output 12 is 2+...+12 = 77; head wraps 10 -> 0.
- Edge cases:
  - data_length=0 -> ap_done exactly 12 cycles after ap_start (11 CLEAR cycles then DONE); ss_tready never asserted.
  - RST during MAC -> next cycle ap_idle=1 and no ap_done.

Source files
------------

// File: rtl/fir_data_sequencer.sv
// Stream-side FIR engine: circular sample buffer in the data BRAM, one MAC per
// cycle against the tap BRAM, filtered sample emitted on an output stream.
module fir_data_sequencer #(
    parameter int TAPS   = 11,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    output logic              ss_tready,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    output logic              tap_EN,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [DATA_W-1:0] tap_Do,
    output logic [3:0]        data_WE,
    output logic              data_EN,
    output logic [ADDR_W-1:0] data_A,
    output logic [DATA_W-1:0] data_Di,
    input  logic [DATA_W-1:0] data_Do
);
    localparam int KW = $clog2(TAPS);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, MAC, OUT, DONE} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [KW-1:0]     head_q, head_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       len_q, len_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [KW-1:0]     mac_idx;
    logic [DATA_W-1:0] prod;
    logic              last;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [KW-1:0] idx);
        return {{(ADDR_W-KW-2){1'b0}}, idx, 2'b00};
    endfunction

    // Newest sample sits at head; tap k pairs with the sample k positions older.
    always_comb begin
        mac_idx = (head_q >= k_q) ? head_q - k_q : head_q + KW'(TAPS) - k_q;
        // Low DATA_W bits of a product are identical for signed and unsigned operands.
        prod    = tap_Do * data_Do;
        last    = (count_q == len_q - 32'd1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= '0;
            head_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            head_q  <= head_d;
            count_q <= count_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        head_d  = head_q;
        count_d = count_q;
        len_d   = len_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (ap_start) begin
                len_d   = data_length;
                head_d  = '0;
                count_d = '0;
                k_d     = '0;
                state_d = CLEAR;
            end
            CLEAR: if (k_q == KW'(TAPS-1)) begin
                k_d     = '0;
                state_d = (len_q == 32'd0) ? DONE : WAIT_IN;
            end else begin
                k_d = k_q + 1'b1;
            end
            WAIT_IN: if (ss_tvalid) begin
                acc_d   = '0;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + prod;
                if (k_q == KW'(TAPS-1)) begin
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: if (sm_tready) begin
                head_d  = (head_q == KW'(TAPS-1)) ? '0 : head_q + 1'b1;
                count_d = count_q + 32'd1;
                state_d = last ? DONE : WAIT_IN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tdata  = '0;
        sm_tlast  = 1'b0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        data_WE   = 4'h0;
        data_EN   = 1'b0;
        data_A    = '0;
        data_Di   = '0;
        case (state_q)
            IDLE: ap_idle = 1'b1;
            CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(k_q);
            end
            WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = word_addr(head_q);
                    data_Di = ss_tdata;
                end
            end
            MAC: begin
                tap_EN  = 1'b1;
                tap_A   = word_addr(k_q);
                data_EN = 1'b1;
                data_A  = word_addr(mac_idx);
            end
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = acc_q;
                sm_tlast  = last;
            end
            DONE:    ap_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fir_data_sequencer.sv
// Directed bench for fir_data_sequencer with behavioural tap/data BRAMs.
module tb_fir_data_sequencer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ap_start = 1'b0;
    logic [31:0] data_length = '0;
    logic        ap_idle, ap_done;
    logic        ss_tvalid = 1'b0;
    logic [31:0] ss_tdata = '0;
    logic        ss_tready;
    logic        sm_tvalid, sm_tlast;
    logic [31:0] sm_tdata;
    logic        sm_tready = 1'b1;
    logic        tap_EN, data_EN;
    logic [11:0] tap_A, data_A;
    logic [31:0] tap_Do, data_Do, data_Di;
    logic [3:0]  data_WE;

    logic [31:0] tap_mem  [0:15];
    logic [31:0] data_mem [0:15];

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int tready_seen = 0;

    always #5 CLK = ~CLK;

    fir_data_sequencer dut (
        .CLK(CLK), .RST(RST), .ap_start(ap_start), .data_length(data_length),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_WE(data_WE), .data_EN(data_EN), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do)
    );

    assign tap_Do  = tap_mem[tap_A[5:2]];
    assign data_Do = data_mem[data_A[5:2]];

    always @(posedge CLK)
        if (data_EN && data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;

    always @(negedge CLK) begin
        if (ap_done) done_cnt++;
        if (ss_tready) tready_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_taps(input logic [31:0] v);
        for (int i = 0; i < 16; i++) tap_mem[i] = (i < 11) ? v : 32'h0;
    endtask

    task automatic start(input logic [31:0] len);
        @(negedge CLK);
        ap_start = 1'b1;
        data_length = len;
        @(negedge CLK);
        ap_start = 1'b0;
    endtask

    // Offers one sample, then checks latency, data and tlast of the result.
    task automatic send_sample(input logic [31:0] d, input logic [31:0] exp, input logic exp_last);
        int n;
        @(negedge CLK);
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        n = 0;
        while (!ss_tready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("in_timeout", 32'd0, 32'd1);
        @(negedge CLK);
        ss_tvalid = 1'b0;
        n = 1;
        while (!sm_tvalid && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("latency", n, 32'd12);
        chk("tdata", sm_tdata, exp);
        chk("tlast", {31'd0, sm_tlast}, {31'd0, exp_last});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ap_idle && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", {31'd0, ap_idle}, 32'd1);
    endtask

    logic [31:0] wrap_exp [0:14] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66, 77, 88, 99, 110};

    initial begin
        int d0, n;
        set_taps(32'd0);

        repeat (3) @(negedge CLK);
        chk("rst_idle",   {31'd0, ap_idle},   32'd1);
        chk("rst_tready", {31'd0, ss_tready}, 32'd0);
        chk("rst_tvalid", {31'd0, sm_tvalid}, 32'd0);
        chk("rst_done",   {31'd0, ap_done},   32'd0);
        chk("rst_we",     {28'd0, data_WE},   32'd0);
        chk("rst_den",    {31'd0, data_EN},   32'd0);
        RST = 1'b0;

        // Impulse: outputs reproduce the taps, then drop to zero.
        for (int i = 0; i < 11; i++) tap_mem[i] = i + 1;
        d0 = done_cnt;
        start(32'd12);
        for (int i = 0; i < 12; i++)
            send_sample((i == 0) ? 32'd1 : 32'd0, (i < 11) ? i + 1 : 0, i == 11);
        wait_idle();
        chk("impulse_done", done_cnt - d0, 32'd1);

        // Leftover samples of run 1 must not leak into run 2.
        set_taps(32'd1);
        start(32'd3);
        send_sample(32'd5, 32'd5, 1'b0);
        send_sample(32'd5, 32'd10, 1'b0);
        send_sample(32'd5, 32'd15, 1'b1);
        wait_idle();
        start(32'd1);
        send_sample(32'd1, 32'd1, 1'b1);
        wait_idle();

        // Output held under backpressure.
        start(32'd2);
        sm_tready = 1'b0;
        send_sample(32'd3, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 0 || i == 4) begin
                chk("bp_tvalid", {31'd0, sm_tvalid}, 32'd1);
                chk("bp_tdata",  sm_tdata, 32'd3);
                chk("bp_tlast",  {31'd0, sm_tlast}, 32'd0);
                chk("bp_tready", {31'd0, ss_tready}, 32'd0);
            end
        end
        sm_tready = 1'b1;
        send_sample(32'd4, 32'd7, 1'b1);
        wait_idle();

        // Product keeps only the low 32 bits.
        set_taps(32'd0);
        tap_mem[0] = 32'h7FFF_FFFF;
        start(32'd1);
        send_sample(32'd2, 32'hFFFF_FFFE, 1'b1);
        wait_idle();

        // Head wraps past the end of the buffer.
        set_taps(32'd1);
        start(32'd15);
        for (int i = 0; i < 15; i++) send_sample(i + 1, wrap_exp[i], i == 14);
        wait_idle();

        // Zero-length run: CLEAR then DONE, stream never ready.
        d0 = tready_seen;
        start(32'd0);
        n = 1;
        while (!ap_done && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("len0_done_lat", n, 32'd12);
        chk("len0_tready", tready_seen - d0, 32'd0);
        wait_idle();

        // Reset during MAC aborts silently.
        d0 = done_cnt;
        start(32'd2);
        @(negedge CLK);
        ss_tvalid = 1'b1;
        ss_tdata  = 32'd9;
        n = 0;
        while (!ss_tready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        ss_tvalid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mac_active", {31'd0, tap_EN}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_idle", {31'd0, ap_idle}, 32'd1);
        chk("abort_tapen", {31'd0, tap_EN}, 32'd0);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        chk("abort_nodone", done_cnt - d0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
